// File: rtl/keyboard_fifo.sv
// rtl/keyboard_fifo.sv - edge-qualified circular keyboard receive FIFO with sticky overflow
// Optional macro KB_BACKSPACE_EN: 08/7F bytes delete the newest queued character instead of being stored.
module keyboard_fifo #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 7,
    parameter int RX_W   = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   KB_clear,
    input  logic [RX_W-1:0]        rx_data,
    input  logic                   rx_done,
    input  logic                   KB_read_en,
    output logic [DATA_W-1:0]      KB_data,
    output logic                   KB_status,
    output logic                   buf_full,
    output logic                   overflow,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              rx_d_q, rd_d_q, overflow_q, overflow_d;
    logic [DATA_W-1:0] kb_data_q, kb_data_d;
    logic              kb_status_q, buf_full_q;
    logic [DATA_W-1:0] wdata;
    logic              push_req, pop_req, is_bs, pop_do, push_do, bs_do, ovf_set;
    logic              unused_rx;

    assign wdata     = rx_data[DATA_W-1:0];
    assign unused_rx = ^rx_data;
    assign push_req  = rx_done & ~rx_d_q & ~KB_clear;
    assign pop_req   = KB_read_en & ~rd_d_q & ~KB_clear;

`ifdef KB_BACKSPACE_EN
    assign is_bs = push_req && ((wdata == DATA_W'(8'h08)) || (wdata == DATA_W'(8'h7F)));
`else
    assign is_bs = 1'b0;
`endif

    assign pop_do  = pop_req && (count_q != '0);
    assign push_do = push_req && !is_bs && ((count_q != FULL_CNT) || pop_do);
    assign ovf_set = push_req && !is_bs && (count_q == FULL_CNT) && !pop_do;
    // A backspace racing the pop of the only entry must not remove it twice.
    assign bs_do   = is_bs && (count_q != '0) && !(pop_do && (count_q == CNT_W'(1)));

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | ovf_set;
        if (KB_clear) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (push_do) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (bs_do)   wr_ptr_d = wr_ptr_q - PTR_W'(1);
            if (pop_do)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push_do) - CNT_W'(pop_do) - CNT_W'(bs_do);
        end
        // The head may be the entry being written this cycle, so bypass the array.
        if (count_d == '0)
            kb_data_d = '0;
        else if (push_do && (wr_ptr_q == rd_ptr_d))
            kb_data_d = wdata;
        else
            kb_data_d = mem_q[rd_ptr_d];
    end

    always_ff @(posedge clk) begin
        if (push_do) mem_q[wr_ptr_q] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rx_d_q      <= 1'b0;
            rd_d_q      <= 1'b0;
            overflow_q  <= 1'b0;
            kb_data_q   <= '0;
            kb_status_q <= 1'b0;
            buf_full_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rx_d_q      <= rx_done;
            rd_d_q      <= KB_read_en;
            overflow_q  <= overflow_d;
            kb_data_q   <= kb_data_d;
            kb_status_q <= (count_d != '0);
            buf_full_q  <= (count_d == FULL_CNT);
        end
    end

    assign KB_data   = kb_data_q;
    assign KB_status = kb_status_q;
    assign buf_full  = buf_full_q;
    assign overflow  = overflow_q;
    assign count     = count_q;
endmodule

// File: tb/tb_keyboard_fifo.sv
// tb/tb_keyboard_fifo.sv - directed self-checking bench for keyboard_fifo
module tb_keyboard_fifo;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       KB_clear = 1'b0;
    logic       rx_done = 1'b0;
    logic       KB_read_en = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic [6:0] KB_data;
    logic       KB_status, buf_full, overflow;
    logic [4:0] count;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    keyboard_fifo #(.DEPTH(16), .DATA_W(7), .RX_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .KB_clear(KB_clear), .rx_data(rx_data),
        .rx_done(rx_done), .KB_read_en(KB_read_en), .KB_data(KB_data),
        .KB_status(KB_status), .buf_full(buf_full), .overflow(overflow), .count(count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b, input int hold);
        @(negedge clk);
        rx_data = b;
        rx_done = 1'b1;
        repeat (hold) @(negedge clk);
        rx_done = 1'b0;
    endtask

    task automatic pop(input int hold);
        @(negedge clk);
        KB_read_en = 1'b1;
        repeat (hold) @(negedge clk);
        KB_read_en = 1'b0;
    endtask

    task automatic push_pop(input logic [7:0] b);
        @(negedge clk);
        rx_data    = b;
        rx_done    = 1'b1;
        KB_read_en = 1'b1;
        @(negedge clk);
        rx_done    = 1'b0;
        KB_read_en = 1'b0;
    endtask

    task automatic clear();
        @(negedge clk);
        KB_clear = 1'b1;
        @(negedge clk);
        KB_clear = 1'b0;
    endtask

    initial begin
        logic [7:0] hw [11];
        logic [7:0] bs_exp [4];
        int         bs_n;
        hw = '{8'h68, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20, 8'h77, 8'h6F, 8'h72, 8'h6C, 8'h64};

        repeat (2) @(negedge clk);
        check("rst_count", 32'(count), 32'd0);
        check("rst_status", 32'(KB_status), 32'd0);
        check("rst_data", 32'(KB_data), 32'd0);
        check("rst_full", 32'(buf_full), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        rst_n = 1'b1;

        push(8'h68, 2);
        check("single_count", 32'(count), 32'd1);
        check("single_status", 32'(KB_status), 32'd1);
        check("single_data", 32'(KB_data), 32'h68);
        pop(1);
        check("single_pop_count", 32'(count), 32'd0);

        for (int i = 0; i < 11; i++) push(hw[i], 1);
        check("hello_count", 32'(count), 32'd11);
        for (int i = 0; i < 11; i++) begin
            check($sformatf("hello_data%0d", i), 32'(KB_data), 32'(hw[i] & 8'h7F));
            pop(3);
        end
        check("hello_end_count", 32'(count), 32'd0);
        check("hello_end_status", 32'(KB_status), 32'd0);
        check("hello_end_data", 32'(KB_data), 32'd0);

        for (int i = 0; i < 16; i++) push(8'(8'h41 + i), 1);
        check("full_count", 32'(count), 32'd16);
        check("full_flag", 32'(buf_full), 32'd1);
        check("full_ovf_pre", 32'(overflow), 32'd0);
        push(8'h51, 1);
        check("ovf_count", 32'(count), 32'd16);
        check("ovf_flag", 32'(overflow), 32'd1);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("ovf_data%0d", i), 32'(KB_data), 32'(8'h41 + i));
            pop(1);
        end
        check("ovf_drain_count", 32'(count), 32'd0);
        check("ovf_drain_full", 32'(buf_full), 32'd0);
        check("ovf_sticky", 32'(overflow), 32'd1);
        clear();
        check("ovf_cleared", 32'(overflow), 32'd0);

        for (int i = 0; i < 16; i++) push(8'(8'h41 + i), 1);
        push_pop(8'h5A);
        check("fullpp_count", 32'(count), 32'd16);
        check("fullpp_ovf", 32'(overflow), 32'd0);
        check("fullpp_data", 32'(KB_data), 32'h42);
        clear();

        for (int i = 0; i < 10; i++) push(8'(8'h10 + i), 1);
        for (int i = 0; i < 10; i++) pop(1);
        for (int i = 0; i < 10; i++) push(8'(8'h30 + i), 1);
        check("wrap_count", 32'(count), 32'd10);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("wrap_data%0d", i), 32'(KB_data), 32'(8'h30 + i));
            pop(1);
        end
        check("wrap_end_count", 32'(count), 32'd0);

        for (int i = 0; i < 5; i++) push(8'(8'h20 + i), 1);
        @(negedge clk);
        KB_clear = 1'b1;
        rx_data  = 8'h55;
        rx_done  = 1'b1;
        @(negedge clk);
        KB_clear = 1'b0;
        check("clr_count", 32'(count), 32'd0);
        check("clr_ovf", 32'(overflow), 32'd0);
        check("clr_status", 32'(KB_status), 32'd0);
        check("clr_data", 32'(KB_data), 32'd0);
        @(negedge clk);
        check("clr_held_count", 32'(count), 32'd0);
        rx_done = 1'b0;

        pop(1);
        check("empty_pop_count", 32'(count), 32'd0);
        push_pop(8'h4B);
        check("emptypp_count", 32'(count), 32'd1);
        check("emptypp_data", 32'(KB_data), 32'h4B);
        pop(1);
        check("emptypp_drain", 32'(count), 32'd0);

        @(negedge clk);
        rx_data = 8'h4D;
        rx_done = 1'b1;
        @(negedge clk);
        check("midrst_pre", 32'(count), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_count", 32'(count), 32'd0);
        check("midrst_status", 32'(KB_status), 32'd0);
        check("midrst_data", 32'(KB_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("postrst_count", 32'(count), 32'd1);
        check("postrst_data", 32'(KB_data), 32'h4D);
        rx_done = 1'b0;
        clear();

        push(8'h61, 1);
        push(8'h62, 1);
        push(8'h08, 1);
        push(8'h63, 1);
`ifdef KB_BACKSPACE_EN
        bs_exp = '{8'h61, 8'h63, 8'h00, 8'h00};
        bs_n   = 2;
`else
        bs_exp = '{8'h61, 8'h62, 8'h08, 8'h63};
        bs_n   = 4;
`endif
        check("bs_count", 32'(count), 32'(bs_n));
        for (int i = 0; i < bs_n; i++) begin
            check($sformatf("bs_data%0d", i), 32'(KB_data), 32'(bs_exp[i]));
            pop(1);
        end
        check("bs_end_count", 32'(count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
